// File: rtl/pep_mainsubs_side_join.sv
// pep_mainsubs_side_join
//   Main-side endpoint of the pe_pbs main <-> subs side channel.
//   Collects per-subs event pulses (ack/done), counts the outstanding ones
//   per subs and per event type, and emits one joined pulse to main once
//   every subs partition has reported that event. Also replicates the
//   main-side proc word to every subs through a register pipeline.
//
// Ports
//   clk        : clock
//   a_rst      : asynchronous active-high reset
//   subs_evt   : single-cycle event pulses, subs s / event e at bit s*EVT_NB+e
//   main_evt   : registered joined event pulses to main
//   main_bcast : proc word from main (level)
//   subs_bcast : replicated proc word, slice s for subs s
//   cnt_clr    : synchronous clear of counters and error flags
//   pending    : bit e set while any subs still holds an unjoined event e
//   error      : sticky per-event counter overflow flag
module pep_mainsubs_side_join #(
  parameter int unsigned SUBS_NB         = 2,
  parameter int unsigned EVT_NB          = 3,
  parameter int unsigned CNT_W           = 4,
  parameter int unsigned IN_PIPE         = 1,
  parameter int unsigned OUT_PIPE        = 1,
  parameter int unsigned MAINSUBS_PROC_W = 25,
  parameter int unsigned BCAST_W         = MAINSUBS_PROC_W
) (
  input  logic                       clk,
  input  logic                       a_rst,
  input  logic [SUBS_NB*EVT_NB-1:0]  subs_evt,
  output logic [EVT_NB-1:0]          main_evt,
  input  logic [BCAST_W-1:0]         main_bcast,
  output logic [SUBS_NB*BCAST_W-1:0] subs_bcast,
  input  logic                       cnt_clr,
  output logic [EVT_NB-1:0]          pending,
  output logic [EVT_NB-1:0]          error
);

  localparam int unsigned    EW      = SUBS_NB * EVT_NB;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Input stage
  // ---------------------------------------------------------------------------
  logic [EW-1:0] evt_stg;

  generate
    if (IN_PIPE == 0) begin : g_in_comb
      assign evt_stg = subs_evt;
    end else begin : g_in_pipe
      logic [EW-1:0] in_pipe [IN_PIPE];

      always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
          for (int unsigned i = 0; i < IN_PIPE; i++) in_pipe[i] <= '0;
        end else begin
          in_pipe[0] <= subs_evt;
          for (int unsigned i = 1; i < IN_PIPE; i++) in_pipe[i] <= in_pipe[i-1];
        end
      end

      assign evt_stg = in_pipe[IN_PIPE-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Join counters
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]  cnt_q [EW];
  logic [CNT_W-1:0]  cnt_d [EW];
  logic [EVT_NB-1:0] fire;
  logic [EVT_NB-1:0] ovf;

  always_comb begin
    fire = '0;
    ovf  = '0;

    // An event fires when every subs has either a stored count or a pulse
    // arriving right now; a clear suppresses the join for that cycle.
    for (int unsigned e = 0; e < EVT_NB; e++) begin
      fire[e] = !cnt_clr;
      for (int unsigned s = 0; s < SUBS_NB; s++) begin
        if ((cnt_q[s*EVT_NB+e] == '0) && !evt_stg[s*EVT_NB+e]) fire[e] = 1'b0;
      end
    end

    for (int unsigned s = 0; s < SUBS_NB; s++) begin
      for (int unsigned e = 0; e < EVT_NB; e++) begin
        cnt_d[s*EVT_NB+e] = cnt_q[s*EVT_NB+e];
        if (cnt_clr) begin
          cnt_d[s*EVT_NB+e] = '0;
        end else if (fire[e]) begin
          // A pulse arriving while firing is consumed in place.
          if (!evt_stg[s*EVT_NB+e]) cnt_d[s*EVT_NB+e] = cnt_q[s*EVT_NB+e] - CNT_ONE;
        end else if (evt_stg[s*EVT_NB+e]) begin
          if (cnt_q[s*EVT_NB+e] == CNT_MAX) ovf[e] = 1'b1;
          else cnt_d[s*EVT_NB+e] = cnt_q[s*EVT_NB+e] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      for (int unsigned i = 0; i < EW; i++) cnt_q[i] <= '0;
      main_evt <= '0;
      error    <= '0;
    end else begin
      for (int unsigned i = 0; i < EW; i++) cnt_q[i] <= cnt_d[i];
      main_evt <= fire;
      error    <= cnt_clr ? '0 : (error | ovf);
    end
  end

  always_comb begin
    pending = '0;
    for (int unsigned s = 0; s < SUBS_NB; s++) begin
      for (int unsigned e = 0; e < EVT_NB; e++) begin
        if (cnt_q[s*EVT_NB+e] != '0) pending[e] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Broadcast path
  // ---------------------------------------------------------------------------
  logic [BCAST_W-1:0] bcast;

  generate
    if (OUT_PIPE == 0) begin : g_bc_comb
      assign bcast = main_bcast;
    end else begin : g_bc_pipe
      logic [BCAST_W-1:0] bc_pipe [OUT_PIPE];

      always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
          for (int unsigned i = 0; i < OUT_PIPE; i++) bc_pipe[i] <= '0;
        end else begin
          bc_pipe[0] <= main_bcast;
          for (int unsigned i = 1; i < OUT_PIPE; i++) bc_pipe[i] <= bc_pipe[i-1];
        end
      end

      assign bcast = bc_pipe[OUT_PIPE-1];
    end
  endgenerate

  assign subs_bcast = {SUBS_NB{bcast}};

endmodule

// File: tb/tb_pep_mainsubs_side_join.sv
module tb_pep_mainsubs_side_join;

  localparam int BW = 25;
  localparam logic [BW-1:0] BVAL = 25'h0A5A5A5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [5:0]    evt_a = '0;
  logic [5:0]    evt_b = '0;
  logic          clr_a = 1'b0;
  logic          clr_b = 1'b0;
  logic [BW-1:0] bcast = '0;
  logic [2:0]    mevt_a, mevt_b, pend_a, pend_b, err_a, err_b;
  logic [2*BW-1:0] sb_a, sb_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int phase  = 1;

  always #5 clk = ~clk;

  // Join/pipeline scenarios: CNT_W=4, broadcast through two stages.
  pep_mainsubs_side_join #(
    .SUBS_NB(2), .EVT_NB(3), .CNT_W(4), .IN_PIPE(1), .OUT_PIPE(2),
    .MAINSUBS_PROC_W(BW), .BCAST_W(BW)
  ) dut_a (
    .clk(clk), .a_rst(rst), .subs_evt(evt_a), .main_evt(mevt_a),
    .main_bcast(bcast), .subs_bcast(sb_a), .cnt_clr(clr_a),
    .pending(pend_a), .error(err_a)
  );

  // Saturation scenario: CNT_W=2.
  pep_mainsubs_side_join #(
    .SUBS_NB(2), .EVT_NB(3), .CNT_W(2), .IN_PIPE(1), .OUT_PIPE(1),
    .MAINSUBS_PROC_W(BW), .BCAST_W(BW)
  ) dut_b (
    .clk(clk), .a_rst(rst), .subs_evt(evt_b), .main_evt(mevt_b),
    .main_bcast(bcast), .subs_bcast(sb_b), .cnt_clr(clr_b),
    .pending(pend_b), .error(err_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d phase=%0d observed=%0h expected=%0h", tag, cyc, phase, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic in_rng(int c, int lo, int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  // ---- hand-derived expectations ----
  function automatic logic [2:0] exp_mevt_a(int c);
    if (c == 17)               return 3'b001;
    if (phase == 1 && c == 22) return 3'b010;
    if (phase == 1 && in_rng(c, 42, 46)) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [2:0] exp_pend_a(int c);
    logic [2:0] p;
    p = '0;
    p[0] = in_rng(c, 12, 16) || (phase == 1 && c >= 88);
    p[2] = (phase == 1) && in_rng(c, 32, 45);
    return p;
  endfunction

  function automatic logic [2*BW-1:0] exp_sb(int c, int lat);
    if (phase == 1) return (c >= 50 + lat) ? {BVAL, BVAL} : '0;
    return (c >= lat) ? {BVAL, BVAL} : '0;
  endfunction

  function automatic logic [2:0] exp_mevt_b(int c);
    return (phase == 1 && in_rng(c, 68, 70)) ? 3'b001 : 3'b000;
  endfunction

  function automatic logic [2:0] exp_pend_b(int c);
    if (phase != 1) return 3'b000;
    return {2'b00, in_rng(c, 62, 69) || in_rng(c, 73, 74) || c >= 80};
  endfunction

  function automatic logic [2:0] exp_err_b(int c);
    return {2'b00, (phase == 1) && in_rng(c, 65, 74)};
  endfunction

  // ---- stimulus schedule ----
  function automatic logic [5:0] drv_a(int c);
    if (c == 10) return 6'b000001;
    if (c == 15) return 6'b001000;
    if (phase != 1) return 6'b000000;
    if (c == 20) return 6'b010010;
    if (in_rng(c, 30, 34)) return 6'b000100;
    if (in_rng(c, 40, 44)) return 6'b100000;
    if (c == 86) return 6'b000001;
    if (c == 89) return 6'b001000;
    return 6'b000000;
  endfunction

  function automatic logic [5:0] drv_b(int c);
    if (phase != 1) return 6'b000000;
    if (in_rng(c, 60, 63)) return 6'b000001;
    if (in_rng(c, 66, 68)) return 6'b001000;
    if (c == 71) return 6'b000001;
    if (c == 78) return 6'b001000;
    return 6'b000000;
  endfunction

  task automatic check_cycle();
    chk("main_evt_a", 64'(mevt_a), 64'(exp_mevt_a(cyc)));
    chk("pending_a",  64'(pend_a), 64'(exp_pend_a(cyc)));
    chk("error_a",    64'(err_a),  64'(3'b000));
    chk("bcast_a",    64'(sb_a),   64'(exp_sb(cyc, 2)));
    chk("main_evt_b", 64'(mevt_b), 64'(exp_mevt_b(cyc)));
    chk("pending_b",  64'(pend_b), 64'(exp_pend_b(cyc)));
    chk("error_b",    64'(err_b),  64'(exp_err_b(cyc)));
    chk("bcast_b",    64'(sb_b),   64'(exp_sb(cyc, 1)));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mevt_a"}, 64'(mevt_a), 64'(0));
    chk({tag, "_pend_a"}, 64'(pend_a), 64'(0));
    chk({tag, "_err_a"},  64'(err_a),  64'(0));
    chk({tag, "_sb_a"},   64'(sb_a),   64'(0));
    chk({tag, "_mevt_b"}, 64'(mevt_b), 64'(0));
    chk({tag, "_pend_b"}, 64'(pend_b), 64'(0));
    chk({tag, "_err_b"},  64'(err_b),  64'(0));
    chk({tag, "_sb_b"},   64'(sb_b),   64'(0));
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    cyc = 0;

    // Phase 1: joins, back-to-back, broadcast, saturation/clear, pre-reset load
    while (cyc < 90) begin
      tick();
      check_cycle();
      evt_a = drv_a(cyc);
      evt_b = drv_b(cyc);
      clr_b = (cyc == 74);
      bcast = (cyc >= 50) ? BVAL : '0;
    end

    // Mid-cycle reset with dut_a counter loaded and a pulse in its input pipe
    #4;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    cyc   = 0;
    phase = 2;

    // Phase 2: fresh join after release, no stale events
    while (cyc < 25) begin
      tick();
      check_cycle();
      evt_a = drv_a(cyc);
      evt_b = drv_b(cyc);
      clr_b = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time bound
  initial begin
    #20000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
